nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nsa_pkg.sv | 24 ++
 rtl/rca4_cin.sv | 62 ++++++
 rtl/nibble_serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// +----------------------------------------------------------------------+
// | nsa_pkg: shared types and constants for nibble_serial_adder_ctrl     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // A single-nibble datapath still needs a one-bit index register.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca4_cin.sv
// +----------------------------------------------------------------------+
// | rca4_cin: 4-bit ripple-carry slice with carry-in, built from         |
// | half_adder / full_adder primitives.                  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_s(o_s),  .o_c(w_c1));

  assign o_cout = w_c0 | w_c1;
endmodule

module rca4_cin
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      full_adder u_fa (
        .i_a   (i_a[gi]),
        .i_b   (i_b[gi]),
        .i_cin (w_c[gi]),
        .o_s   (o_sum[gi]),
        .o_cout(w_c[gi+1])
      );
    end
  endgenerate

  assign o_cout = w_c[NIBBLE_W];
endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
// +----------------------------------------------------------------------+
// | nibble_serial_adder_ctrl: WIDTH-bit add, one nibble per clock through |
// | a shared rca4_cin slice. NSA_SUB_EN adds a-b via sub.    Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

  nsa_state_t          r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH:0]      r_sum;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_slice_sum;
  logic                w_slice_cout;

  assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  rca4_cin u_slice (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_cin (r_carry),
    .o_sum (w_slice_sum),
    .o_cout(w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a <= a;
`ifdef NSA_SUB_EN
            // Two's complement subtract: invert b and inject a carry-in.
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
`else
            r_b     <= b;
            r_carry <= 1'b0;
`endif
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_slice_sum;
          r_carry                           <= w_slice_cout;
          if (r_idx == C_LAST_IDX) begin
            r_sum[WIDTH] <= w_slice_cout;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl: directed cases plus randomized
// operations compared against an arithmetic reference model.
`default_nettype none

module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef NSA_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef NSA_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned sum, or a - b biased by 2^W so bit W = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    longint r;
    if (s) r = (longint'(1) << W) + longint'(x) - longint'(y);
    else   r = longint'(x) + longint'(y);
    return r[W:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit ts,
                       input int bp, input bit poke);
    logic [W:0] exp;
    bit eff_sub;
`ifdef NSA_SUB_EN
    eff_sub = ts;
    sub     = ts;
`else
    eff_sub = 1'b0;
`endif
    exp      = model(ta, tb_v, eff_sub);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    check("ov_accept", 32'(out_valid), 32'd0);
    for (int i = 1; i < NIB; i++) begin
      if (poke && i == 1) begin
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h1111;
      end
      step();
      in_valid = 1'b0;
      if (poke && i == 1) check("poke_in_ready", 32'(in_ready), 32'd0);
      check("ov_early", 32'(out_valid), 32'd0);
    end
    step();
    check("ov_latency", 32'(out_valid), 32'd1);
    check("sum", 32'(sum), 32'(exp));
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'(exp));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ov_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("busy_after_hs", 32'(busy), 32'd0);
    check("sum_hold", 32'(sum), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   got_sum [2];
    int           got_cyc [2];
    int           nres, nacc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef NSA_SUB_EN
    sub       = 1'b0;
`endif
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
    check("max_sum", 32'(sum), 32'h1FFFE);
    do_op(16'h0F0F, 16'h2222, 1'b0, 10, 1'b1);
`ifdef NSA_SUB_EN
    do_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
    check("sub_nob", 32'(sum), 32'h10002);
    do_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    check("sub_borrow", 32'(sum), 32'h0FFFE);
`endif

    // Reset in the middle of RUN.
    in_valid = 1'b1;
    a        = 16'hAAAA;
    b        = 16'h5555;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 3; i++) begin
      step();
      check("post_rst_ov", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Back-to-back with in_valid and out_ready held high.
    nres = 0;
    nacc = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 16'h1357;
    b         = 16'h2468;
    for (int cyc = 1; cyc <= 40 && nres < 2; cyc++) begin
      if (in_valid && in_ready) nacc++;
      step();
      if (nacc == 1) begin
        a = 16'h8ACE;
        b = 16'h9BDF;
      end
      if (nacc >= 2) in_valid = 1'b0;
      if (out_valid) begin
        got_sum[nres] = sum;
        got_cyc[nres] = cyc;
        nres++;
      end
    end
    in_valid  = 1'b0;
    check("b2b_count", 32'(nres), 32'd2);
    if (nres == 2) begin
      check("b2b_first", 32'(got_sum[0]), 32'(model(16'h1357, 16'h2468, 1'b0)));
      check("b2b_second", 32'(got_sum[1]), 32'(model(16'h8ACE, 16'h9BDF, 1'b0)));
      check("b2b_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'(NIB + 2));
    end
    step();
    out_ready = 1'b0;
    step();
    check("b2b_idle", 32'(in_ready), 32'd1);

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
